// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC injection scheduler: FSM encoding,
// flit width derivation and the packet counter width.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CNT_WIDTH = 20;

  // Flit = destination x, destination y, payload.
  function automatic int total_width(input int x_size, input int y_size, input int data_width);
    return x_size + y_size + data_width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found when
// searching upward from ptr+1, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // Rotating priority search, first hit wins.
  always_comb begin
    int   idx_s;
    logic found_s;
    logic hit_s;
    gnt     = {N{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s      = (int'(ptr) + 1 + k) % N;
      hit_s      = req[idx_s] & ~found_s;
      gnt[idx_s] = gnt[idx_s] | hit_s;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Shares one router local injection port among NUM_REQ requesters with
// round-robin arbitration, a minimum grant spacing and a per-run packet quota.
module noc_inject_scheduler
  import noc_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int X_SIZE      = 1,
  parameter int Y_SIZE      = 1,
  parameter int DATA_WIDTH  = 256,
  parameter int RATE        = 1,
  parameter int NUM_PACKETS = 5000,
  localparam int TOTAL_WIDTH = total_width(X_SIZE, Y_SIZE, DATA_WIDTH),
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_REQ-1:0]             enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  output logic [TOTAL_WIDTH-1:0]         out_data,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic [CNT_WIDTH-1:0]           sent_count,
  output logic                           done
);

  state_e                 state_r, state_next_s;
  logic [7:0]             gap_r;
  logic [ID_W-1:0]        last_grant_r;
  logic [CNT_WIDTH-1:0]   sent_count_r;
  logic                   out_valid_r;
  logic [TOTAL_WIDTH-1:0] out_data_r;
  logic [ID_W-1:0]        grant_id_r;
  logic                   done_r;

  logic                   slot_free_s;
  logic                   quota_hit_s;
  logic                   grant_ok_s;
  logic [NUM_REQ-1:0]     cand_s;
  logic [NUM_REQ-1:0]     gnt_s;
  logic                   accept_s;
  logic [ID_W-1:0]        sel_id_s;
  logic [TOTAL_WIDTH-1:0] sel_data_s;

  assign slot_free_s = ~out_valid_r | out_ready;
  assign quota_hit_s = (sent_count_r == CNT_WIDTH'(NUM_PACKETS));
  // Granting is blocked in the cycle RUN exits, so the quota is never exceeded.
  assign grant_ok_s  = (state_r == ST_RUN) & start & ~quota_hit_s &
                       (gap_r == 8'd0) & slot_free_s;
  assign cand_s      = enable & req_valid & {NUM_REQ{grant_ok_s}};
  assign accept_s    = |gnt_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rr_arbiter (
    .req (cand_s),
    .ptr (last_grant_r),
    .gnt (gnt_s)
  );

  // One-hot grant to requester index and flit mux.
  always_comb begin
    sel_id_s   = {ID_W{1'b0}};
    sel_data_s = {TOTAL_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_id_s   = sel_id_s | (gnt_s[i] ? ID_W'(i) : {ID_W{1'b0}});
      sel_data_s = sel_data_s |
                   (gnt_s[i] ? req_data[i*TOTAL_WIDTH +: TOTAL_WIDTH] : {TOTAL_WIDTH{1'b0}});
    end
  end

  // Run-control next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!start || quota_hit_s) state_next_s = ST_DRAIN;
        else                       state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!out_valid_r) state_next_s = ST_DONE;
        else              state_next_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (!start) state_next_s = ST_IDLE;
        else        state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, counters and the output flit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gap_r        <= 8'd0;
      last_grant_r <= ID_W'(NUM_REQ - 1);
      sent_count_r <= {CNT_WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      out_data_r   <= {TOTAL_WIDTH{1'b0}};
      grant_id_r   <= {ID_W{1'b0}};
      done_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == ST_DONE);
      if (accept_s) begin
        gap_r        <= 8'(RATE - 1);
        last_grant_r <= sel_id_s;
        sent_count_r <= sent_count_r + CNT_WIDTH'(1);
        out_valid_r  <= 1'b1;
        out_data_r   <= sel_data_s;
        grant_id_r   <= sel_id_s;
      end else begin
        gap_r <= (gap_r != 8'd0) ? gap_r - 8'd1 : 8'd0;
        if (out_ready) out_valid_r <= 1'b0;
        if (state_r == ST_DONE && !start) sent_count_r <= {CNT_WIDTH{1'b0}};
      end
    end
  end

  assign req_ready  = gnt_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign grant_id   = grant_id_r;
  assign sent_count = sent_count_r;
  assign done       = done_r;

endmodule
